image_ram_arbiter: RTL and testbench



---
 rtl/image_ram_pkg.sv | 11 +
 rtl/image_ram_arbiter_rd_valid_pipe.sv | 26 ++
 rtl/image_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_image_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/image_ram_pkg.sv
// Shared types and default sizes for the image RAM arbiter and its helpers.
package image_ram_pkg;

   localparam int IMG_ADDR_W = 14;
   localparam int IMG_DATA_W = 24;
   localparam int IMG_DEPTH  = 16384;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY} arb_state_e;
   typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_e;

endpackage

// File: rtl/image_ram_arbiter_rd_valid_pipe.sv
// Delays read-accept tokens by the RAM read latency so the valid strobe lines up with q.
module rd_valid_pipe #(
   parameter int LAT = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tok_i,
   output logic tok_o
);

   logic [LAT-1:0] tok_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tok_q <= '0;
      end else begin
         tok_q[0] <= tok_i;
         for (int i = 1; i < LAT; i++) begin
            tok_q[i] <= tok_q[i-1];
         end
      end
   end

   assign tok_o = tok_q[LAT-1];

endmodule

// File: rtl/image_ram_arbiter.sv
// Shares one single-port image RAM between an auto-addressed frame write stream
// and a random-access reader, alternating grants when both compete.
module image_ram_arbiter
   import image_ram_pkg::*;
#(
   parameter int ADDR_W = IMG_ADDR_W,
   parameter int DATA_W = IMG_DATA_W,
   parameter int DEPTH  = IMG_DEPTH,
   parameter int RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_wr_valid,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   input  logic              i_rd_valid,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_ready,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_data_valid,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_data,
   output logic              o_ram_wren,
   input  logic [DATA_W-1:0] i_ram_q
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   grant_e            last_grant_q, last_grant_d;
   grant_e            grant;
   logic              frame_done_q, frame_done_d;
   logic              filling;
   logic              contested;
   logic              wr_acc;
   logic              rd_acc;
   logic              last_wr;

   assign filling   = (state_q == S_FILL);
   assign contested = filling && i_wr_valid && i_rd_valid;

   // Readiness looks only at the opposite side's valid, so a requester's own
   // valid never feeds back into its ready.
   assign o_wr_ready = filling && (!i_rd_valid || (last_grant_q == GNT_RD));
   assign o_rd_ready = !filling || !i_wr_valid || (last_grant_q == GNT_WR);

   assign wr_acc  = i_wr_valid && o_wr_ready;
   assign rd_acc  = i_rd_valid && o_rd_ready;
   assign last_wr = wr_acc && (ptr_q == LAST_PTR);

   always_comb begin
      grant = GNT_NONE;
      if (wr_acc) begin
         grant = GNT_WR;
      end else if (rd_acc) begin
         grant = GNT_RD;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (contested) begin
         last_grant_d = grant;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (i_start) begin
         ptr_d = '0;
      end else if (wr_acc) begin
         ptr_d = last_wr ? '0 : ptr_q + ADDR_W'(1);
      end
   end

   // A restart landing on the final write cancels the completion pulse.
   assign frame_done_d = last_wr && !i_start;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (i_start) state_d = S_FILL;
         S_FILL: begin
            if (i_start) begin
               state_d = S_FILL;
            end else if (last_wr) begin
               state_d = S_READY;
            end
         end
         S_READY: if (i_start) state_d = S_FILL;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy     = filling;
      o_ram_wren = (grant == GNT_WR);
      o_ram_addr = (grant == GNT_RD) ? i_rd_addr : ptr_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q        <= '0;
         last_grant_q <= GNT_RD;
         frame_done_q <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         last_grant_q <= last_grant_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign o_frame_done = frame_done_q;
   assign o_ram_data   = i_wr_data;
   assign o_rd_data    = i_ram_q;

   rd_valid_pipe #(
      .LAT(RD_LAT)
   ) u_rd_valid_pipe (
      .clk_i (i_clk),
      .rst_ni(i_rst_n),
      .tok_i (rd_acc),
      .tok_o (o_rd_data_valid)
   );

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Bench for image_ram_arbiter: per-cycle vector records for the handshakes and RAM
// drive, plus a scoreboard of expected read returns checked against a RAM model.
module tb_image_ram_arbiter;

   localparam int AW = 3;
   localparam int DW = 24;
   localparam int DP = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          wv;
   logic [DW-1:0] wd;
   logic          rv;
   logic [AW-1:0] ra;
   logic          wr_ready, rd_ready, rd_dv, busy, done, ram_wren;
   logic [DW-1:0] rd_data, ram_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_q;

   logic          wr_ready3, rd_ready3, rd_dv3, busy3, done3, ram_wren3;
   logic [DW-1:0] rd_data3, ram_data3;
   logic [AW-1:0] ram_addr3;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic          start;
      logic          wv;
      logic [DW-1:0] wd;
      logic          rv;
      logic [AW-1:0] ra;
      logic          ewr;
      logic          erd;
      logic          ewren;
      logic [AW-1:0] eaddr;
      logic          ebusy;
      logic          edone;
      logic          ret;
      logic [DW-1:0] erdata;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } ret_t;

   ret_t sb[$];
   vec_t vecs[$];
   logic [DW-1:0] mem [DP];

   image_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .RD_LAT(1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_wr_valid(wv), .i_wr_data(wd), .o_wr_ready(wr_ready),
      .i_rd_valid(rv), .i_rd_addr(ra), .o_rd_ready(rd_ready),
      .o_rd_data(rd_data), .o_rd_data_valid(rd_dv),
      .o_busy(busy), .o_frame_done(done),
      .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_wren(ram_wren),
      .i_ram_q(ram_q)
   );

   image_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .RD_LAT(3)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_wr_valid(wv), .i_wr_data(wd), .o_wr_ready(wr_ready3),
      .i_rd_valid(rv), .i_rd_addr(ra), .o_rd_ready(rd_ready3),
      .o_rd_data(rd_data3), .o_rd_data_valid(rd_dv3),
      .o_busy(busy3), .o_frame_done(done3),
      .o_ram_addr(ram_addr3), .o_ram_data(ram_data3), .o_ram_wren(ram_wren3),
      .i_ram_q(ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM model with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      ret_t r;
      if (rst_n && rd_dv) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got valid data %h, expected no return (cycle %0d)", rd_data, cyc);
         end else begin
            r = sb.pop_front();
            $display("[TB] read return data=%h cycle=%0d", rd_data, cyc);
            chk("rd_data", 32'(rd_data), 32'(r.data));
            chk("rd_cycle", 32'(cyc), 32'(r.due));
         end
      end
   end

   function automatic vec_t mk(input int st, input int w_v, input int w_d, input int r_v,
                               input int r_a, input int e_wr, input int e_rd, input int e_wren,
                               input int e_addr, input int e_busy, input int e_done,
                               input int e_ret, input int e_rdata);
      vec_t v;
      v.start  = st[0];
      v.wv     = w_v[0];
      v.wd     = DW'(w_d);
      v.rv     = r_v[0];
      v.ra     = AW'(r_a);
      v.ewr    = e_wr[0];
      v.erd    = e_rd[0];
      v.ewren  = e_wren[0];
      v.eaddr  = AW'(e_addr);
      v.ebusy  = e_busy[0];
      v.edone  = e_done[0];
      v.ret    = e_ret[0];
      v.erdata = DW'(e_rdata);
      return v;
   endfunction

   task automatic run_row(input vec_t v, input string tag);
      start = v.start;
      wv    = v.wv;
      wd    = v.wd;
      rv    = v.rv;
      ra    = v.ra;
      #1;
      chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(v.ewr));
      chk({tag, ".rd_ready"}, 32'(rd_ready), 32'(v.erd));
      chk({tag, ".ram_wren"}, 32'(ram_wren), 32'(v.ewren));
      chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(v.eaddr));
      chk({tag, ".busy"}, 32'(busy), 32'(v.ebusy));
      chk({tag, ".frame_done"}, 32'(done), 32'(v.edone));
      if (v.ret) sb.push_back('{data: v.erdata, due: cyc + 1});
      @(posedge clk);
      #1;
      start = 1'b0;
      wv    = 1'b0;
      wd    = '0;
      rv    = 1'b0;
      ra    = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      wv    = 1'b0;
      wd    = '0;
      rv    = 1'b0;
      ra    = '0;

      // Idle, one fill of 1..8 with no reads, then reads in the ready state.
      vecs.push_back(mk(0, 1, 'h99, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) vecs.push_back(mk(0, 1, k + 1, 0, 0, 1, 0, 1, k, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 'h99, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 'h99, 1, 3, 0, 1, 0, 3, 0, 0, 1, 4));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 7, 0, 1, 0, 7, 0, 0, 1, 8));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset.rd_dv", 32'(rd_dv), 32'd0);
      chk("reset.rd_dv3", 32'(rd_dv3), 32'd0);

      for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], $sformatf("vec%0d", i));

      // Full contention: grants alternate starting with write, frame ends after 16 cycles.
      run_row(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "cont_start");
      for (int i = 0; i < 16; i++) begin
         int j;
         j = i / 2;
         if (i == 15)
            run_row(mk(0, 1, 'hA07, 1, 7, 0, 1, 0, 7, 0, 1, 1, 'hA07), "cont_last");
         else if (i % 2 == 0)
            run_row(mk(0, 1, 'hA00 + j, 1, j, 1, 0, 1, j, 1, 0, 0, 0), $sformatf("cont_w%0d", j));
         else
            run_row(mk(0, 1, 'hA00 + j, 1, j, 0, 1, 0, j, 1, 0, 1, 'hA00 + j), $sformatf("cont_r%0d", j));
      end
      run_row(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "cont_idle");

      // Restart mid-fill, then restart coincident with the final write.
      run_row(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "rs_start");
      for (int k = 0; k < 5; k++) run_row(mk(0, 1, 'hB00 + k, 0, 0, 1, 1, 1, k, 1, 0, 0, 0), $sformatf("rs_b%0d", k));
      run_row(mk(1, 0, 0, 0, 0, 1, 1, 0, 5, 1, 0, 0, 0), "rs_restart");
      for (int k = 0; k < 7; k++) run_row(mk(0, 1, 'hC00 + k, 0, 0, 1, 1, 1, k, 1, 0, 0, 0), $sformatf("rs_c%0d", k));
      run_row(mk(1, 1, 'hC07, 0, 0, 1, 1, 1, 7, 1, 0, 0, 0), "rs_final_start");
      run_row(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0), "rs_no_done");
      run_row(mk(0, 0, 0, 1, 7, 0, 1, 0, 7, 1, 0, 1, 'hC07), "rs_rd7");
      run_row(mk(0, 0, 0, 1, 4, 0, 1, 0, 4, 1, 0, 1, 'hC04), "rs_rd4");
      run_row(mk(0, 1, 'hD00, 1, 5, 0, 1, 0, 5, 1, 0, 1, 'hC05), "rs_contest_r");
      run_row(mk(0, 1, 'hD00, 1, 5, 1, 0, 1, 0, 1, 0, 0, 0), "rs_contest_w");

      // Reset with read tags in flight: returns are dropped.
      run_row(mk(0, 0, 0, 1, 2, 0, 1, 0, 2, 1, 0, 0, 0), "rst_rd");
      rst_n = 1'b0;
      #1;
      chk("rst.rd_dv", 32'(rd_dv), 32'd0);
      chk("rst.rd_dv3", 32'(rd_dv3), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.ram_addr", 32'(ram_addr), 32'd0);
      chk("rst.wr_ready", 32'(wr_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("rst_hold.rd_dv3", 32'(rd_dv3), 32'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("post_rst.rd_dv3", 32'(rd_dv3), 32'd0);
         chk("post_rst.busy", 32'(busy), 32'd0);
         @(posedge clk);
         #1;
      end

      // Three-cycle read latency on the second instance.
      run_row(mk(0, 0, 0, 1, 2, 0, 1, 0, 2, 0, 0, 1, 'hC02), "lat_rd");
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("lat3_valid_n%0d", k), 32'(rd_dv3), (k == 3) ? 32'd1 : 32'd0);
         @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
